// File: rtl/hex_ascii_pkg.sv
// Shared ASCII-hex definitions for the hex parse and print paths.
// Holds character codes, the parser state encoding and the default word size.
package hex_ascii_pkg;

   localparam int NDIGITS_DEF = 16;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_A_UP = 8'h41;
   localparam logic [7:0] CH_F_UP = 8'h46;
   localparam logic [7:0] CH_A_LO = 8'h61;
   localparam logic [7:0] CH_F_LO = 8'h66;
   localparam logic [7:0] CH_CR   = 8'h0D;
   localparam logic [7:0] CH_LF   = 8'h0A;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   typedef struct packed {
      logic       is_digit;
      logic       is_term;
      logic [3:0] nibble;
   } char_class_t;

endpackage

// File: rtl/hex_to_bin_if.sv
// Character-in / word-out bundle of the hex parser.
// slave = parser side, master = receiver/consumer side.
interface hex_to_bin_if
   import hex_ascii_pkg::*;
#(
   parameter int NDIGITS = NDIGITS_DEF
);
   localparam int DATA_W = 4 * NDIGITS;
   localparam int CNT_W  = $clog2(NDIGITS + 1);

   logic [7:0]        char_in;
   logic              char_valid;
   logic              char_ready;
   logic              consume_done;
   logic [DATA_W-1:0] binary_out;
   logic [CNT_W-1:0]  digit_count;
   logic              binary_ready;
   logic              char_error;

   modport slave (
      input  char_in, char_valid, consume_done,
      output char_ready, binary_out, digit_count, binary_ready, char_error
   );

   modport master (
      output char_in, char_valid, consume_done,
      input  char_ready, binary_out, digit_count, binary_ready, char_error
   );

endinterface

// File: rtl/ascii_hex_nibble.sv
// Combinational ASCII classifier: hex digit (with value), line terminator, or neither.
// Reusable by the print path for round-trip checks.
module ascii_hex_nibble
   import hex_ascii_pkg::*;
(
   input  logic [7:0]  i_char,
   output char_class_t o_class
);

   // NOTE: every field gets a default before the decode so no latch is inferred.
   always_comb begin
      o_class = '0;
      if (i_char >= CH_0 && i_char <= CH_9) begin
         o_class.is_digit = 1'b1;
         o_class.nibble   = i_char[3:0];
      end else if ((i_char >= CH_A_UP && i_char <= CH_F_UP) ||
                   (i_char >= CH_A_LO && i_char <= CH_F_LO)) begin
         o_class.is_digit = 1'b1;
         o_class.nibble   = i_char[3:0] + 4'd9;
      end else if (i_char == CH_CR || i_char == CH_LF) begin
         o_class.is_term  = 1'b1;
      end
   end

endmodule

// File: rtl/hex_to_bin.sv
// Serial ASCII-hex to binary word parser; the word is held until the consumer releases it.
// Two-process FSM: next values computed combinationally, all state registered below.
module hex_to_bin
   import hex_ascii_pkg::*;
#(
   parameter int NDIGITS = NDIGITS_DEF
) (
   input logic          clk,
   input logic          rst_n,
   hex_to_bin_if.slave  bus
);

   localparam int DATA_W = 4 * NDIGITS;
   localparam int CNT_W  = $clog2(NDIGITS + 1);

   state_t            r_state;
   logic [DATA_W-1:0] r_acc;
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_out;
   logic [CNT_W-1:0]  r_dcnt;
   logic              r_ready;
   logic              r_err;

   state_t            w_state_nxt;
   logic [DATA_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [DATA_W-1:0] w_out_nxt;
   logic [CNT_W-1:0]  w_dcnt_nxt;
   logic              w_ready_nxt;
   logic              w_err_nxt;

   char_class_t       w_class;
   logic              w_xfer;
   logic [DATA_W-1:0] w_shifted;

   ascii_hex_nibble u_nibble (
      .i_char  (bus.char_in),
      .o_class (w_class)
   );

   assign w_xfer    = bus.char_valid && (r_state == ST_ACCUM);
   assign w_shifted = {r_acc[DATA_W-5:0], w_class.nibble};

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_count_nxt = r_count;
      w_out_nxt   = r_out;
      w_dcnt_nxt  = r_dcnt;
      w_ready_nxt = r_ready;
      w_err_nxt   = 1'b0;
      case (r_state)
         ST_ACCUM: begin
            if (w_xfer) begin
               if (w_class.is_digit) begin
                  if (r_count == CNT_W'(NDIGITS - 1)) begin
                     // Last digit position: the word completes without a terminator.
                     w_out_nxt   = w_shifted;
                     w_dcnt_nxt  = CNT_W'(NDIGITS);
                     w_ready_nxt = 1'b1;
                     w_acc_nxt   = '0;
                     w_count_nxt = '0;
                     w_state_nxt = ST_HOLD;
                  end else begin
                     w_acc_nxt   = w_shifted;
                     w_count_nxt = r_count + 1'b1;
                  end
               end else if (w_class.is_term) begin
                  if (r_count != '0) begin
                     w_out_nxt   = r_acc;
                     w_dcnt_nxt  = r_count;
                     w_ready_nxt = 1'b1;
                     w_acc_nxt   = '0;
                     w_count_nxt = '0;
                     w_state_nxt = ST_HOLD;
                  end
               end else begin
                  w_err_nxt   = 1'b1;
                  w_acc_nxt   = '0;
                  w_count_nxt = '0;
               end
            end
         end
         ST_HOLD: begin
            if (bus.consume_done) begin
               w_ready_nxt = 1'b0;
               w_state_nxt = ST_ACCUM;
            end
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
         r_acc   <= '0;
         r_count <= '0;
         r_out   <= '0;
         r_dcnt  <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_count <= w_count_nxt;
         r_out   <= w_out_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_ready <= w_ready_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign bus.char_ready   = (r_state == ST_ACCUM);
   assign bus.binary_out   = r_out;
   assign bus.digit_count  = r_dcnt;
   assign bus.binary_ready = r_ready;
   assign bus.char_error   = r_err;

endmodule

// File: tb/tb_hex_to_bin.sv
// Directed self-checking bench for hex_to_bin: vector table of complete words
// plus hand-written sequences for HOLD, terminator and reset corner cases.
module tb_hex_to_bin;
   import hex_ascii_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   hex_to_bin_if #(.NDIGITS(16)) bus ();

   hex_to_bin #(.NDIGITS(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [191:0] seq;
      logic [7:0]   len;
      logic [63:0]  exp_out;
      logic [4:0]   exp_cnt;
      logic [7:0]   exp_errs;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that samples the char.
   task automatic send_char(input logic [7:0] c);
      bus.char_in    = c;
      bus.char_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.char_valid = 1'b0;
      bus.char_in    = 8'h00;
   endtask

   task automatic consume();
      bus.consume_done = 1'b1;
      @(posedge clk);
      #1;
      bus.consume_done = 1'b0;
   endtask

   task automatic check_word(input string name, input logic [63:0] v, input logic [4:0] n);
      check({name, " ready"}, 64'(bus.binary_ready), 64'd1);
      check({name, " out"}, bus.binary_out, v);
      check({name, " count"}, 64'(bus.digit_count), 64'(n));
      check({name, " char_ready"}, 64'(bus.char_ready), 64'd0);
   endtask

   task automatic check_idle(input string name);
      check({name, " ready"}, 64'(bus.binary_ready), 64'd0);
      check({name, " char_ready"}, 64'(bus.char_ready), 64'd1);
   endtask

   initial begin
      n_checks         = 0;
      n_fail           = 0;
      rst_n            = 1'b0;
      bus.char_in      = 8'h00;
      bus.char_valid   = 1'b0;
      bus.consume_done = 1'b0;

      vecs[0] = '{seq: 192'("0123456789ABCDEF"), len: 8'd16, exp_out: 64'h0123456789ABCDEF, exp_cnt: 5'd16, exp_errs: 8'd0};
      vecs[1] = '{seq: 192'("1f\r"),              len: 8'd3,  exp_out: 64'h1F,               exp_cnt: 5'd2,  exp_errs: 8'd0};
      vecs[2] = '{seq: 192'("12G3\n"),            len: 8'd5,  exp_out: 64'h3,                exp_cnt: 5'd1,  exp_errs: 8'd1};
      vecs[3] = '{seq: 192'("fedcba9876543210"), len: 8'd16, exp_out: 64'hFEDCBA9876543210, exp_cnt: 5'd16, exp_errs: 8'd0};
      vecs[4] = '{seq: 192'("\nA5\r"),            len: 8'd4,  exp_out: 64'hA5,               exp_cnt: 5'd2,  exp_errs: 8'd0};
      vecs[5] = '{seq: 192'("000fF\n"),           len: 8'd6,  exp_out: 64'hFF,               exp_cnt: 5'd5,  exp_errs: 8'd0};

      repeat (2) @(posedge clk);
      #1;
      check("reset out", bus.binary_out, 64'd0);
      check("reset count", 64'(bus.digit_count), 64'd0);
      check("reset error", 64'(bus.char_error), 64'd0);
      check_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         int errs;
         int len;
         errs = 0;
         len  = int'(vecs[i].len);
         for (int k = 0; k < len; k++) begin
            send_char(vecs[i].seq[8*(len-1-k) +: 8]);
            if (bus.char_error === 1'b1) errs++;
            if (k < len - 1)
               check($sformatf("v%0d early ready c%0d", i, k), 64'(bus.binary_ready), 64'd0);
         end
         check_word($sformatf("v%0d", i), vecs[i].exp_out, vecs[i].exp_cnt);
         check($sformatf("v%0d errors", i), 64'(errs), 64'(vecs[i].exp_errs));
         consume();
         check_idle($sformatf("v%0d release", i));
      end

      // Terminators with nothing collected: after auto-completion, and a lone LF.
      for (int k = 0; k < 16; k++) send_char(8'h30 + 8'(k % 10));
      check_word("auto", 64'h0123456789012345, 5'd16);
      consume();
      send_char(CH_CR);
      check("trail cr error", 64'(bus.char_error), 64'd0);
      check_idle("trail cr");
      send_char(CH_LF);
      check("lone lf error", 64'(bus.char_error), 64'd0);
      check_idle("lone lf");

      // Chars during HOLD are dropped, including one alongside consume_done.
      send_char("5");
      send_char(CH_LF);
      check_word("hold5", 64'h5, 5'd1);
      send_char("9");
      check_word("hold ignore", 64'h5, 5'd1);
      check("hold ignore error", 64'(bus.char_error), 64'd0);
      bus.char_in      = "8";
      bus.char_valid   = 1'b1;
      bus.consume_done = 1'b1;
      @(posedge clk);
      #1;
      bus.char_valid   = 1'b0;
      bus.consume_done = 1'b0;
      check_idle("same cycle");
      send_char(CH_LF);
      check_idle("same cycle not taken");
      send_char("7");
      consume();
      send_char(CH_LF);
      check_word("consume in accum", 64'h7, 5'd1);
      consume();

      // Reset mid-word discards the partial word.
      send_char("A");
      send_char("B");
      rst_n = 1'b0;
      #1;
      check_idle("mid rst");
      check("mid rst out", bus.binary_out, 64'd0);
      check("mid rst count", 64'(bus.digit_count), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_char("C");
      send_char(CH_LF);
      check_word("after rst", 64'hC, 5'd1);

      // Reset also clears a pending word.
      rst_n = 1'b0;
      #1;
      check_idle("pend rst");
      check("pend rst out", bus.binary_out, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
